// File: rtl/kudu_pkg.sv
// Shared types for the kudu branch replay block: the recorded branch
// record and the replay controller state.
package kudu_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
    } branch_rec_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } replay_state_e;

endpackage

// File: rtl/kudu_branch_rec_fifo.sv
// Circular record buffer with one write port and two read ports
// (head and head+1); the consumer pops 0, 1 or 2 entries per cycle.
module kudu_branch_rec_fifo
    import kudu_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  branch_rec_t                push_rec_i,
    input  logic [1:0]                 pop_cnt_i,
    output branch_rec_t                head_rec_o,
    output branch_rec_t                next_rec_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       ready_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    branch_rec_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          wr_en;

    // No bypass: a full buffer refuses the load even if entries pop this cycle.
    assign ready_o = (level < LW'(DEPTH));
    assign wr_en   = push_i & ready_o & ~flush_i;

    // Storage is never reset; only entries counted by level are ever read.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_rec_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_en);
            rd_ptr <= rd_ptr + AW'(pop_cnt_i);
            level  <= level + LW'(wr_en) - LW'(pop_cnt_i);
        end
    end

    assign head_rec_o = mem[rd_ptr];
    assign next_rec_o = mem[rd_ptr + AW'(1)];
    assign level_o    = level;

endmodule

// File: rtl/kudu_branch_replay.sv
// Branch replay unit: streams previously recorded branch outcomes back to
// two issue lanes, flagging PC mismatches and running out of records.
module kudu_branch_replay
    import kudu_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_stop_i,
    input  logic                   flush_i,
    input  logic                   ld_valid_i,
    output logic                   ld_ready_o,
    input  logic [31:0]            ld_pc_i,
    input  logic [31:0]            ld_target_i,
    input  logic                   ld_taken_i,
    input  logic [1:0]             req_i,
    input  logic [1:0][31:0]       req_pc_i,
    output logic [1:0]             rsp_valid_o,
    output logic [1:0]             rsp_taken_o,
    output logic [1:0]             rsp_mismatch_o,
    output logic [1:0][31:0]       rsp_target_o,
    output logic                   underflow_o,
    output logic                   replay_en_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic [CNT_W-1:0]       rec_cnt_o
);

    localparam int LW = $clog2(DEPTH) + 1;

    replay_state_e state, state_nxt;
    branch_rec_t   ld_rec, head_rec, next_rec, lane1_rec;
    logic [LW-1:0] level;
    logic [1:0]    pop_cnt;
    logic          serve0, serve1, uf;
    logic [CNT_W:0] cnt_sum;

    assign ld_rec = '{pc: ld_pc_i, target: ld_target_i, taken: ld_taken_i};

    kudu_branch_rec_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .push_i     (ld_valid_i),
        .push_rec_i (ld_rec),
        .pop_cnt_i  (pop_cnt),
        .head_rec_o (head_rec),
        .next_rec_o (next_rec),
        .level_o    (level),
        .ready_o    (ld_ready_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Lane 1 takes the record behind lane 0 when both lanes issue; a lane
    // without a record stops serving there and raises the underflow.
    always_comb begin
        serve0    = 1'b0;
        serve1    = 1'b0;
        uf        = 1'b0;
        lane1_rec = req_i[0] ? next_rec : head_rec;
        if (state == ST_RUN && !flush_i) begin
            if (req_i[0]) begin
                if (level != '0) serve0 = 1'b1;
                else             uf     = 1'b1;
            end
            if (req_i[1]) begin
                if (req_i[0]) begin
                    if (level >= LW'(2)) serve1 = 1'b1;
                    else                 uf     = 1'b1;
                end else begin
                    if (level != '0) serve1 = 1'b1;
                    else             uf     = 1'b1;
                end
            end
        end
    end

    assign pop_cnt = {serve0 & serve1, serve0 ^ serve1};
    assign cnt_sum = {1'b0, rec_cnt_o} + (CNT_W+1)'(pop_cnt);

    // Underflow outranks a coincident start/stop pulse.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_stop_i) state_nxt = ST_RUN;
            ST_RUN: begin
                if (uf)                state_nxt = ST_ERR;
                else if (start_stop_i) state_nxt = ST_IDLE;
            end
            ST_ERR:  if (start_stop_i) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rec_cnt_o   <= '0;
            underflow_o <= 1'b0;
        end else begin
            if (state == ST_IDLE && start_stop_i) begin
                rec_cnt_o <= '0;
            end else if (cnt_sum[CNT_W]) begin
                rec_cnt_o <= '1;
            end else begin
                rec_cnt_o <= cnt_sum[CNT_W-1:0];
            end
            if (uf) begin
                underflow_o <= 1'b1;
            end else if (state == ST_ERR && start_stop_i) begin
                underflow_o <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_o    <= '0;
            rsp_taken_o    <= '0;
            rsp_mismatch_o <= '0;
            rsp_target_o   <= '0;
        end else begin
            rsp_valid_o       <= {serve1, serve0};
            rsp_taken_o[0]    <= serve0 & head_rec.taken;
            rsp_taken_o[1]    <= serve1 & lane1_rec.taken;
            rsp_mismatch_o[0] <= serve0 & (head_rec.pc != req_pc_i[0]);
            rsp_mismatch_o[1] <= serve1 & (lane1_rec.pc != req_pc_i[1]);
            rsp_target_o[0]   <= serve0 ? head_rec.target : 32'h0;
            rsp_target_o[1]   <= serve1 ? lane1_rec.target : 32'h0;
        end
    end

    assign replay_en_o = (state == ST_RUN);
    assign level_o     = level;

endmodule

// File: tb/tb_kudu_branch_replay.sv
// Directed self-checking bench for kudu_branch_replay (DEPTH=16, CNT_W=16).
module tb_kudu_branch_replay;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             start_stop_i, flush_i, ld_valid_i, ld_taken_i;
    logic             ld_ready_o, underflow_o, replay_en_o;
    logic [31:0]      ld_pc_i, ld_target_i;
    logic [1:0]       req_i, rsp_valid_o, rsp_taken_o, rsp_mismatch_o;
    logic [1:0][31:0] req_pc_i, rsp_target_o;
    logic [4:0]       level_o;
    logic [15:0]      rec_cnt_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    kudu_branch_replay #(.DEPTH(16), .CNT_W(16)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_stop_i   (start_stop_i),
        .flush_i        (flush_i),
        .ld_valid_i     (ld_valid_i),
        .ld_ready_o     (ld_ready_o),
        .ld_pc_i        (ld_pc_i),
        .ld_target_i    (ld_target_i),
        .ld_taken_i     (ld_taken_i),
        .req_i          (req_i),
        .req_pc_i       (req_pc_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_taken_o    (rsp_taken_o),
        .rsp_mismatch_o (rsp_mismatch_o),
        .rsp_target_o   (rsp_target_o),
        .underflow_o    (underflow_o),
        .replay_en_o    (replay_en_o),
        .level_o        (level_o),
        .rec_cnt_o      (rec_cnt_o)
    );

    // Inputs change 1ns after the rising edge, outputs are read there too.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        start_stop_i = 1'b0;
        flush_i      = 1'b0;
        ld_valid_i   = 1'b0;
        ld_pc_i      = '0;
        ld_target_i  = '0;
        ld_taken_i   = 1'b0;
        req_i        = '0;
        req_pc_i     = '0;
    endtask

    task automatic load(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        ld_valid_i = 1'b1; ld_pc_i = pc; ld_target_i = tgt; ld_taken_i = tk;
        step();
        idle_inputs();
    endtask

    task automatic pulse_start();
        start_stop_i = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        vectors++; if (replay_en_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_en got %b exp 0", replay_en_o); end
        vectors++; if (level_o !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_level got %0d exp 0", level_o); end
        vectors++; if (ld_ready_o !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready got %b exp 1", ld_ready_o); end
        vectors++; if (rsp_valid_o !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_rsp got %b exp 00", rsp_valid_o); end
        vectors++; if (underflow_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_uf got %b exp 0", underflow_o); end
        vectors++; if (rec_cnt_o !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_cnt got %0d exp 0", rec_cnt_o); end
    endtask

    task automatic test_dual_issue();
        load(32'h100, 32'h1100, 1'b1);
        load(32'h200, 32'h2200, 1'b0);
        load(32'h300, 32'h3300, 1'b1);
        vectors++; if (level_o !== 5'd3) begin miscompares++; $display("[TB] FAIL load_level got %0d exp 3", level_o); end
        pulse_start();
        vectors++; if (replay_en_o !== 1'b1) begin miscompares++; $display("[TB] FAIL start_en got %b exp 1", replay_en_o); end
        req_i = 2'b11; req_pc_i[0] = 32'h100; req_pc_i[1] = 32'h200;
        step();
        idle_inputs();
        vectors++; if (rsp_valid_o !== 2'b11) begin miscompares++; $display("[TB] FAIL dual_valid got %b exp 11", rsp_valid_o); end
        vectors++; if (rsp_taken_o !== 2'b01) begin miscompares++; $display("[TB] FAIL dual_taken got %b exp 01", rsp_taken_o); end
        vectors++; if (rsp_mismatch_o !== 2'b00) begin miscompares++; $display("[TB] FAIL dual_mism got %b exp 00", rsp_mismatch_o); end
        vectors++; if (rsp_target_o[0] !== 32'h1100 || rsp_target_o[1] !== 32'h2200) begin
            miscompares++; $display("[TB] FAIL dual_target got %h/%h exp 1100/2200", rsp_target_o[0], rsp_target_o[1]); end
        vectors++; if (level_o !== 5'd1) begin miscompares++; $display("[TB] FAIL dual_level got %0d exp 1", level_o); end
        vectors++; if (rec_cnt_o !== 16'd2) begin miscompares++; $display("[TB] FAIL dual_cnt got %0d exp 2", rec_cnt_o); end
        step();
        vectors++; if (rsp_valid_o !== 2'b00) begin miscompares++; $display("[TB] FAIL rsp_one_cycle got %b exp 00", rsp_valid_o); end
    endtask

    task automatic test_underflow();
        req_i = 2'b11; req_pc_i[0] = 32'h300; req_pc_i[1] = 32'h400;
        step();
        idle_inputs();
        vectors++; if (rsp_valid_o !== 2'b01) begin miscompares++; $display("[TB] FAIL uf_valid got %b exp 01", rsp_valid_o); end
        vectors++; if (rsp_target_o[0] !== 32'h3300) begin miscompares++; $display("[TB] FAIL uf_target got %h exp 3300", rsp_target_o[0]); end
        vectors++; if (underflow_o !== 1'b1) begin miscompares++; $display("[TB] FAIL uf_flag got %b exp 1", underflow_o); end
        vectors++; if (replay_en_o !== 1'b0) begin miscompares++; $display("[TB] FAIL uf_err_en got %b exp 0", replay_en_o); end
        vectors++; if (level_o !== 5'd0) begin miscompares++; $display("[TB] FAIL uf_level got %0d exp 0", level_o); end
        vectors++; if (rec_cnt_o !== 16'd3) begin miscompares++; $display("[TB] FAIL uf_cnt got %0d exp 3", rec_cnt_o); end
        load(32'h500, 32'h5500, 1'b1);
        vectors++; if (level_o !== 5'd1) begin miscompares++; $display("[TB] FAIL err_load got %0d exp 1", level_o); end
        req_i = 2'b01; req_pc_i[0] = 32'h500;
        step();
        idle_inputs();
        vectors++; if (rsp_valid_o !== 2'b00 || level_o !== 5'd1) begin
            miscompares++; $display("[TB] FAIL err_ignore got valid %b level %0d exp 00/1", rsp_valid_o, level_o); end
        pulse_start();
        vectors++; if (underflow_o !== 1'b0 || replay_en_o !== 1'b0) begin
            miscompares++; $display("[TB] FAIL err_exit got uf %b en %b exp 0/0", underflow_o, replay_en_o); end
        do_flush();
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) load(32'h1000 + 32'(i), 32'h7000 + 32'(i), 1'b0);
        vectors++; if (ld_ready_o !== 1'b0 || level_o !== 5'd16) begin
            miscompares++; $display("[TB] FAIL full got ready %b level %0d exp 0/16", ld_ready_o, level_o); end
        pulse_start();
        ld_valid_i = 1'b1; ld_pc_i = 32'hFFFF; ld_target_i = 32'hFFFF;
        req_i = 2'b11; req_pc_i[0] = 32'h1000; req_pc_i[1] = 32'h1001;
        step();
        idle_inputs();
        vectors++; if (level_o !== 5'd14) begin miscompares++; $display("[TB] FAIL nobypass_level got %0d exp 14", level_o); end
        vectors++; if (ld_ready_o !== 1'b1) begin miscompares++; $display("[TB] FAIL nobypass_ready got %b exp 1", ld_ready_o); end
        vectors++; if (rsp_valid_o !== 2'b11 || rsp_mismatch_o !== 2'b00) begin
            miscompares++; $display("[TB] FAIL full_pop got valid %b mism %b exp 11/00", rsp_valid_o, rsp_mismatch_o); end
        vectors++; if (rec_cnt_o !== 16'd2) begin miscompares++; $display("[TB] FAIL full_cnt got %0d exp 2", rec_cnt_o); end
        do_flush();
        vectors++; if (level_o !== 5'd0 || replay_en_o !== 1'b1) begin
            miscompares++; $display("[TB] FAIL flush_keep got level %0d en %b exp 0/1", level_o, replay_en_o); end
    endtask

    task automatic test_wrap_mismatch();
        logic [31:0] pc;
        for (int k = 0; k < 20; k++) begin
            pc = (k == 16) ? 32'hBEEF : 32'h2000 + 32'(k);
            load(pc, 32'h9000 + 32'(k), 1'(k % 2));
            req_i = 2'b01; req_pc_i[0] = (k == 16) ? 32'hDEAD : pc;
            step();
            idle_inputs();
            vectors++;
            if (rsp_valid_o !== 2'b01 || rsp_target_o[0] !== 32'h9000 + 32'(k) ||
                rsp_taken_o[0] !== 1'(k % 2) || rsp_mismatch_o[0] !== (k == 16)) begin
                miscompares++;
                $display("[TB] FAIL wrap_%0d got v%b t%h k%b m%b exp v01 t%h k%b m%b", k, rsp_valid_o,
                         rsp_target_o[0], rsp_taken_o[0], rsp_mismatch_o[0], 32'h9000 + 32'(k), 1'(k % 2), (k == 16));
            end
        end
        vectors++; if (rec_cnt_o !== 16'd22) begin miscompares++; $display("[TB] FAIL wrap_cnt got %0d exp 22", rec_cnt_o); end
        vectors++; if (replay_en_o !== 1'b1) begin miscompares++; $display("[TB] FAIL wrap_run got %b exp 1", replay_en_o); end
    endtask

    task automatic test_flush_and_reset();
        load(32'hA0, 32'hA1, 1'b1);
        load(32'hB0, 32'hB1, 1'b1);
        flush_i = 1'b1; req_i = 2'b01; req_pc_i[0] = 32'hA0;
        ld_valid_i = 1'b1; ld_pc_i = 32'hC0;
        step();
        idle_inputs();
        vectors++; if (rsp_valid_o !== 2'b00 || level_o !== 5'd0) begin
            miscompares++; $display("[TB] FAIL flush got valid %b level %0d exp 00/0", rsp_valid_o, level_o); end
        vectors++; if (underflow_o !== 1'b0 || replay_en_o !== 1'b1) begin
            miscompares++; $display("[TB] FAIL flush_state got uf %b en %b exp 0/1", underflow_o, replay_en_o); end
        load(32'hD0, 32'hD1, 1'b1);
        req_i = 2'b01; req_pc_i[0] = 32'hD0;
        step();
        idle_inputs();
        load(32'hE0, 32'hE1, 1'b1);
        #2 rst_ni = 1'b0;
        #1;
        vectors++; if (replay_en_o !== 1'b0 || level_o !== 5'd0 || ld_ready_o !== 1'b1) begin
            miscompares++; $display("[TB] FAIL areset_ctl got en %b level %0d ready %b exp 0/0/1", replay_en_o, level_o, ld_ready_o); end
        vectors++; if (rsp_valid_o !== 2'b00 || rsp_taken_o !== 2'b00 || rec_cnt_o !== 16'd0 || underflow_o !== 1'b0) begin
            miscompares++; $display("[TB] FAIL areset_out got v%b t%b cnt %0d uf %b exp 00/00/0/0", rsp_valid_o, rsp_taken_o, rec_cnt_o, underflow_o); end
        step();
        rst_ni = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst_ni = 1'b0;
        #1;
        test_reset();
        step();
        rst_ni = 1'b1;
        step();
        test_dual_issue();
        test_underflow();
        test_full();
        test_wrap_mismatch();
        test_flush_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/kudu_branch_replay.md
KUDU_BRANCH_REPLAY -- requirements
Module: kudu_branch_replay

Interface
REQ-001 SHALL have parameter DEPTH, default 16, record buffer entries; power of 2, >= 4.
REQ-002 SHALL have parameter CNT_W, default 16, width of consumed-record counter.
REQ-003 SHALL have port clk_i, input, 1: clock.
REQ-004 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start_stop_i, input, 1: single-cycle pulse toggling replay enable.
REQ-006 SHALL have port flush_i, input, 1: synchronous buffer clear.
REQ-007 SHALL have port ld_valid_i / ld_ready_o, input / output, 1 each: record load handshake.
REQ-008 SHALL have ports ld_pc_i, ld_target_i, ld_taken_i, input, 32/32/1: record to load.
REQ-009 SHALL have port req_i, input, 2: per-lane branch-issued strobe (lane 0 = older).
REQ-010 SHALL have port req_pc_i, input, 2x32: per-lane issued branch PC.
REQ-011 SHALL have ports rsp_valid_o, rsp_taken_o, rsp_mismatch_o, output, 2 each: per-lane response.
REQ-012 SHALL have port rsp_target_o, output, 2x32: per-lane recorded target.
REQ-013 SHALL have port underflow_o, output, 1: sticky request-without-record error.
REQ-014 SHALL have port replay_en_o, output, 1: high in RUN.
REQ-015 SHALL have ports level_o and rec_cnt_o, output, $clog2(DEPTH)+1 and CNT_W: occupancy and records consumed.

Function
REQ-016 SHALL hold records {pc, target, taken} in a circular FIFO; the load fire condition is ld_valid_i & ld_ready_o.
REQ-017 SHALL drive ld_ready_o = (level < DEPTH); same-cycle pops SHALL NOT raise ld_ready_o (no bypass).
REQ-018 SHALL make a loaded record visible to requests no earlier than the cycle after it is written.
REQ-019 SHALL implement states IDLE, RUN, ERR; reset state IDLE.
REQ-020 SHALL transition IDLE->RUN on start_stop_i, RUN->IDLE on start_stop_i, RUN->ERR on underflow, and ERR->IDLE on start_stop_i.
REQ-021 SHALL on IDLE->RUN clear rec_cnt_o; SHALL on ERR->IDLE clear underflow_o.
REQ-022 SHALL accept loads in all states; requests SHALL be ignored in IDLE and ERR.
REQ-023 SHALL, in RUN, serve lane 0 from head and lane 1 from head+1 if req_i[0], else from head.
REQ-024 SHALL pop exactly the number of served lanes per cycle (0, 1 or 2), with pointer wrap modulo DEPTH.
REQ-025 SHALL treat any requested lane lacking a record as underflow: serve only the available older lane(s), set underflow_o, enter ERR.
REQ-026 SHALL register responses: rsp_* valid exactly 1 cycle after the serving req_i cycle, with rsp_valid_o=0 for unserved lanes.
REQ-027 SHALL set rsp_mismatch_o[i] = (record pc != req_pc_i[i]) for served lanes; a mismatch SHALL NOT stop replay.
REQ-028 SHALL update level = level + push - pops each cycle; simultaneous push and double pop are legal.
REQ-029 SHALL increment rec_cnt_o by the served count, saturating at all-ones.
REQ-030 SHALL, on flush_i, zero pointers and level, suppressing same-cycle push, pop and responses; state is unchanged.
REQ-031 SHALL give a start_stop_i in the same cycle as an underflow priority to the underflow, entering ERR.

Reset
REQ-032 SHALL, while rst_ni is low, force state IDLE, pointers/level 0, rsp_* 0, underflow_o 0, replay_en_o 0, rec_cnt_o 0, ld_ready_o 1.
REQ-033 SHALL NOT require buffer storage to be reset; unread entries are never observable.

Structure
REQ-034 SHALL take branch_rec_t {pc, target, taken} and the replay state enum from shared package kudu_pkg.
REQ-035 SHALL instantiate one sub-module kudu_branch_rec_fifo (1 write port, 2 read ports at head/head+1, pop count 0..2).

Verification
REQ-036 Load 3 records (pc 0x100/0x200/0x300, taken 1/0/1), pulse start, req_i=2'b11 pc 0x100/0x200 -> next cycle rsp_valid=2'b11, taken=2'b01, mismatch=0, level=1, rec_cnt=2.
REQ-037 Level=1, req_i=2'b11 in RUN -> rsp_valid=2'b01, underflow_o=1, state ERR; a further req ignored; start_stop -> IDLE, underflow_o=0.
REQ-038 Fill 16 records -> ld_ready_o=0; same cycle ld_valid with 2 pops -> load refused, next cycle level=14, ld_ready_o=1.
REQ-039 20 load/pop pairs across wrap, req_pc 0xDEAD for record 0xBEEF on record 17 -> only that rsp_mismatch_o=1, data order preserved.
REQ-040 flush_i with req_i=2'b01 and ld_valid_i same cycle -> no response, level=0; async reset mid-RUN -> all outputs per REQ-032.
